// File: rtl/apb_arbiter_pkg.sv
// Shared definitions for the two-port APB arbiter: bus widths, FSM state
// encoding and the two-way round-robin pick function.
package apb_arbiter_pkg;

    localparam int APB_ADDR_W = 17;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    // One-hot pick between two requesters; last_m1 set means requester 1
    // was served last, so requester 0 wins a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_m1);
        logic [1:0] gnt;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_m1 ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/apb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant from the eligible
// request vector and the served-last pointer, gated by enable.
module rr_arb2
    import apb_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       enable_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // Grant only while the master is free to start a new transfer
    always_comb begin
        gnt_o = 2'b00;
        if (enable_i) begin
            gnt_o = rr_pick(req_i, last_i);
        end else begin
            gnt_o = 2'b00;
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Two-port APB master sharing one APB memory slave between two requesters.
// Round-robin arbitration, SETUP/ACCESS sequencing, registered outputs.
// Optional build macro APB_ARBITER_TIMEOUT_EN aborts an ACCESS phase after
// TIMEOUT cycles without valid and flags it on mX_err; otherwise ACCESS
// waits indefinitely and mX_err is tied low.
module apb_arbiter
    import apb_arbiter_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              valid
);

    apb_state_e        state_q;
    logic [1:0]        gnt_q;
    logic              last_m1_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              pwrite_q;
    logic              psel_q;
    logic              penable_q;
    logic              m0_done_q;
    logic              m1_done_q;
    logic [1:0]        elig_d;
    logic [1:0]        grant_d;

`ifdef APB_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic              m0_err_q;
    logic              m1_err_q;
`endif

    // A requester in its own done cycle is masked so a one-cycle-late req
    // drop cannot start a duplicate transfer
    always_comb begin
        elig_d = {m1_req & ~m1_done_q, m0_req & ~m0_done_q};
    end

    rr_arb2 u_rr_arb2 (
        .req_i    (elig_d),
        .enable_i (state_q == ST_IDLE),
        .last_i   (last_m1_q),
        .gnt_o    (grant_d)
    );

    // Transfer FSM with datapath capture, completion pulses and pointer update
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            last_m1_q <= 1'b1;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
`ifdef APB_ARBITER_TIMEOUT_EN
            tmo_cnt_q <= '0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
`endif
        end else begin
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
`ifdef APB_ARBITER_TIMEOUT_EN
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (grant_d != 2'b00) begin
                        paddr_q   <= grant_d[1] ? m1_addr  : m0_addr;
                        pwrite_q  <= grant_d[1] ? m1_write : m0_write;
                        pwdata_q  <= grant_d[1] ? m1_wdata : m0_wdata;
                        gnt_q     <= grant_d;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= ST_SETUP;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
`ifdef APB_ARBITER_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (valid) begin
                        if (!pwrite_q) begin
                            rdata_q <= prdata;
                        end else begin
                            rdata_q <= rdata_q;
                        end
                        m0_done_q <= gnt_q[0];
                        m1_done_q <= gnt_q[1];
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        last_m1_q <= gnt_q[1];
                        state_q   <= ST_IDLE;
                    end
`ifdef APB_ARBITER_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        m0_done_q <= gnt_q[0];
                        m1_done_q <= gnt_q[1];
                        m0_err_q  <= gnt_q[0];
                        m1_err_q  <= gnt_q[1];
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        last_m1_q <= gnt_q[1];
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
`else
                    else begin
                        state_q <= ST_ACCESS;
                    end
`endif
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pwrite  = pwrite_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign rdata   = rdata_q;
    assign m0_done = m0_done_q;
    assign m1_done = m1_done_q;
`ifdef APB_ARBITER_TIMEOUT_EN
    assign m0_err  = m0_err_q;
    assign m1_err  = m1_err_q;
`else
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
`endif

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus randomized
// two-requester traffic scored against a transaction-level memory model.
module tb_apb_arbiter;

    localparam int AW  = 17;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_t;
    logic [1:0]    wr_t;
    logic [AW-1:0] addr_t [2];
    logic [DW-1:0] wdata_t [2];
    logic          m0_done, m0_err, m1_done, m1_err;
    logic [DW-1:0] rdata, pwdata, prdata;
    logic [AW-1:0] paddr;
    logic          pwrite, psel, penable, valid;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    apb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (req_t[0]),
        .m0_write (wr_t[0]),
        .m0_addr  (addr_t[0]),
        .m0_wdata (wdata_t[0]),
        .m0_done  (m0_done),
        .m0_err   (m0_err),
        .m1_req   (req_t[1]),
        .m1_write (wr_t[1]),
        .m1_addr  (addr_t[1]),
        .m1_wdata (wdata_t[1]),
        .m1_done  (m1_done),
        .m1_err   (m1_err),
        .rdata    (rdata),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .psel     (psel),
        .penable  (penable),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .valid    (valid)
    );

    // Slave model: memory, programmable valid delay, optional valid noise outside ACCESS
    logic [DW-1:0] slv_mem [int];
    logic [DW-1:0] model_mem [int];
    int  slv_delay  = 0;
    int  cur_delay  = 0;
    int  acc_cnt    = 0;
    bit  rand_delay = 1'b0;
    bit  noise_en   = 1'b0;

    initial begin
        valid  = 1'b0;
        prdata = '0;
    end

    always @(negedge clk) begin
        if (psel === 1'b1 && penable === 1'b1) begin
            if (acc_cnt == cur_delay) begin
                valid = 1'b1;
                if (pwrite) begin
                    slv_mem[int'(paddr)] = pwdata;
                    prdata = $urandom;
                end else begin
                    prdata = slv_mem.exists(int'(paddr)) ? slv_mem[int'(paddr)] : 32'h0;
                end
            end else begin
                valid  = 1'b0;
                prdata = $urandom;
            end
            acc_cnt++;
        end else begin
            acc_cnt   = 0;
            cur_delay = rand_delay ? int'($urandom_range(0, 3)) : slv_delay;
            valid     = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            prdata    = $urandom;
        end
    end

    // Monitor: completion counts and exclusivity, sampled just after each edge
    int done_cnt [2];
    bit both_done = 1'b0;
    bit err_seen  = 1'b0;

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    end

    always @(posedge clk) begin
        #1;
        if (m0_done === 1'b1) done_cnt[0]++;
        if (m1_done === 1'b1) done_cnt[1]++;
        if (m0_done === 1'b1 && m1_done === 1'b1) both_done = 1'b1;
        if (m0_err === 1'b1 || m1_err === 1'b1) err_seen = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst   = 1'b0;
        req_t = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        req_t      = 2'b00;
        wr_t       = 2'b00;
        addr_t[0]  = '0;
        addr_t[1]  = '0;
        wdata_t[0] = '0;
        wdata_t[1] = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({psel, penable, pwrite, m0_done, m1_done, m0_err, m1_err} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 0000000", {psel, penable, pwrite, m0_done, m1_done, m0_err, m1_err});
        end
        tests_run++;
        if ({paddr, pwdata, rdata} !== {AW'(0), DW'(0), DW'(0)}) begin
            tests_failed++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want all 0", paddr, pwdata, rdata);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (psel !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_req: psel=%b want 0", psel);
        end
    endtask

    task automatic test_read_basic();
        slv_mem[5] = 32'hDEAD_BEEF;
        slv_delay  = 0;
        req_t[0]   = 1'b1;
        wr_t[0]    = 1'b0;
        addr_t[0]  = 17'd5;
        @(negedge clk);
        tests_run++;
        if ({psel, penable, pwrite, paddr} !== {1'b1, 1'b0, 1'b0, 17'd5}) begin
            tests_failed++;
            $display("FAIL rd_setup: psel=%b penable=%b pwrite=%b paddr=%h want 1 0 0 5", psel, penable, pwrite, paddr);
        end
        @(negedge clk);
        tests_run++;
        if ({psel, penable} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rd_access: psel=%b penable=%b want 1 1", psel, penable);
        end
        @(negedge clk);
        tests_run++;
        if ({m0_done, m0_err, m1_done, psel, penable} !== 5'b10000 || rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL rd_done: done/err/done1/psel/pen=%b rdata=%h want 10000 DEADBEEF", {m0_done, m0_err, m1_done, psel, penable}, rdata);
        end
        req_t[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m0_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_pulse: m0_done=%b want 0", m0_done);
        end
    endtask

    task automatic test_write_delay();
        int base1;
        int w;
        int acc;
        base1      = done_cnt[1];
        slv_delay  = 3;
        req_t[1]   = 1'b1;
        wr_t[1]    = 1'b1;
        addr_t[1]  = 17'd9;
        wdata_t[1] = 32'hAAAA_AAAA;
        w = 0;
        @(negedge clk);
        while (psel !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        tests_run++;
        if (psel !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_grant: psel=%b want 1", psel);
        end
        // Fields change after grant; the transfer must keep the sampled ones
        addr_t[1]  = 17'h1_FFFF;
        wdata_t[1] = 32'h1234_5678;
        wr_t[1]    = 1'b0;
        acc = 0;
        @(negedge clk);
        while (psel === 1'b1 && penable === 1'b1 && acc < 40) begin
            tests_run++;
            if ({paddr, pwdata, pwrite} !== {17'd9, 32'hAAAA_AAAA, 1'b1}) begin
                tests_failed++;
                $display("FAIL wr_hold: paddr=%h pwdata=%h pwrite=%b want 9 AAAAAAAA 1", paddr, pwdata, pwrite);
            end
            acc++;
            @(negedge clk);
        end
        tests_run++;
        if (acc != 4) begin
            tests_failed++;
            $display("FAIL wr_access_len: got %0d want 4", acc);
        end
        tests_run++;
        if ({m1_done, m1_err, m0_done, psel} !== 4'b1000 || rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL wr_done: flags=%b rdata=%h want 1000 DEADBEEF", {m1_done, m1_err, m0_done, psel}, rdata);
        end
        req_t[1] = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_cnt[1] - base1 != 1) begin
            tests_failed++;
            $display("FAIL wr_once: got %0d done pulses want 1", done_cnt[1] - base1);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int when[$];
        int cyc;
        int base0;
        int w;
        apply_reset();
        slv_delay  = 0;
        both_done  = 1'b0;
        wr_t       = 2'b00;
        addr_t[0]  = 17'h10;
        addr_t[1]  = 17'h20;
        req_t      = 2'b11;
        cyc = 0;
        while (order.size() < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m0_done === 1'b1) begin order.push_back(0); when.push_back(cyc); end
            if (m1_done === 1'b1) begin order.push_back(1); when.push_back(cyc); end
            if (order.size() >= 4) req_t = 2'b00;
        end
        req_t = 2'b00;
        tests_run++;
        if (order.size() != 4) begin
            tests_failed++;
            $display("FAIL rr_count: got %0d completions want 4", order.size());
        end
        for (int k = 0; k < order.size() && k < 4; k++) begin
            tests_run++;
            if (order[k] != (k % 2)) begin
                tests_failed++;
                $display("FAIL rr_order[%0d]: got m%0d want m%0d", k, order[k], k % 2);
            end
        end
        for (int k = 1; k < when.size(); k++) begin
            tests_run++;
            if (when[k] - when[k-1] != 3) begin
                tests_failed++;
                $display("FAIL rr_gap[%0d]: got %0d cycles want 3", k, when[k] - when[k-1]);
            end
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (both_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_exclusive: both done seen=%b want 0", both_done);
        end
        // Late drop: req stays high through the done cycle
        base0     = done_cnt[0];
        req_t[0]  = 1'b1;
        w = 0;
        @(negedge clk);
        while (m0_done !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        req_t[0] = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++;
        if (done_cnt[0] - base0 != 1 || psel !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_drop: got %0d dones psel=%b want 1 0", done_cnt[0] - base0, psel);
        end
    endtask

    task automatic test_reset_mid();
        int base0;
        int w;
        base0     = done_cnt[0];
        slv_delay = 6;
        req_t[0]  = 1'b1;
        wr_t[0]   = 1'b0;
        addr_t[0] = 17'd5;
        w = 0;
        @(negedge clk);
        while (!(psel === 1'b1 && penable === 1'b1) && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({psel, penable, m0_done} !== 3'b000 || rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rstmid_bus: psel/pen/done=%b rdata=%h want 000 0", {psel, penable, m0_done}, rdata);
        end
        req_t[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_cnt[0] != base0) begin
            tests_failed++;
            $display("FAIL rstmid_nodone: got %0d extra dones want 0", done_cnt[0] - base0);
        end
        slv_delay = 1;
        req_t[1]  = 1'b1;
        wr_t[1]   = 1'b0;
        addr_t[1] = 17'd9;
        w = 0;
        @(negedge clk);
        while (m1_done !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_t[1] = 1'b0;
        tests_run++;
        if (m1_done !== 1'b1 || m1_err !== 1'b0 || rdata !== 32'hAAAA_AAAA) begin
            tests_failed++;
            $display("FAIL rstmid_recover: done=%b err=%b rdata=%h want 1 0 AAAAAAAA", m1_done, m1_err, rdata);
        end
    endtask

    task automatic test_timeout();
        int w;
        int acc;
        int base1;
        base1     = done_cnt[1];
        err_seen  = 1'b0;
        slv_delay = 1000;
        req_t[1]  = 1'b1;
        wr_t[1]   = 1'b0;
        addr_t[1] = 17'd9;
`ifdef APB_ARBITER_TIMEOUT_EN
        for (int pass = 0; pass < 2; pass++) begin
            // pass 0: slave never answers; pass 1: valid on the last allowed cycle
            slv_delay = (pass == 0) ? 1000 : TMO - 1;
            req_t[1]  = 1'b1;
            w = 0;
            @(negedge clk);
            while (psel !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            acc = 0;
            @(negedge clk);
            while (psel === 1'b1 && penable === 1'b1 && acc < 100) begin
                acc++;
                @(negedge clk);
            end
            req_t[1] = 1'b0;
            tests_run++;
            if (acc != TMO) begin
                tests_failed++;
                $display("FAIL tmo_len[%0d]: got %0d ACCESS cycles want %0d", pass, acc, TMO);
            end
            tests_run++;
            if ({m1_done, m1_err, psel} !== {1'b1, (pass == 0), 1'b0} || rdata !== 32'hAAAA_AAAA) begin
                tests_failed++;
                $display("FAIL tmo_done[%0d]: done/err/psel=%b rdata=%h want 1%0d0 AAAAAAAA", pass, {m1_done, m1_err, psel}, rdata, (pass == 0));
            end
            @(negedge clk);
        end
`else
        repeat (40) @(negedge clk);
        tests_run++;
        if ({psel, penable} !== 2'b11 || err_seen !== 1'b0 || done_cnt[1] != base1) begin
            tests_failed++;
            $display("FAIL notmo_wait: psel/pen=%b err_seen=%b dones=%0d want 11 0 0", {psel, penable}, err_seen, done_cnt[1] - base1);
        end
        apply_reset();
`endif
        slv_delay = 0;
        req_t[0]  = 1'b1;
        wr_t[0]   = 1'b0;
        addr_t[0] = 17'd5;
        w = 0;
        @(negedge clk);
        while (m0_done !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_t[0] = 1'b0;
        tests_run++;
        if (m0_done !== 1'b1 || m0_err !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL tmo_after: done=%b err=%b rdata=%h want 1 0 DEADBEEF", m0_done, m0_err, rdata);
        end
        @(negedge clk);
    endtask

    task automatic drive(input int who, input int n);
        int          gap;
        int          cyc;
        bit          seen;
        logic        w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        for (int k = 0; k < n; k++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 7));
            d = $urandom;
            wr_t[who]    = w;
            addr_t[who]  = a;
            wdata_t[who] = d;
            req_t[who]   = 1'b1;
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if ((who == 0) ? (m0_done === 1'b1) : (m1_done === 1'b1)) seen = 1'b1;
            end
            tests_run++;
            if (!seen) begin
                tests_failed++;
                $display("FAIL rand_wait m%0d txn %0d: no done within 200 cycles", who, k);
            end else begin
                if (!w) begin
                    exp_rd = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 32'h0;
                    if (rdata !== exp_rd || ((who == 0) ? m0_err : m1_err) !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL rand_read m%0d addr %0d: rdata=%h want %h", who, a, rdata, exp_rd);
                    end
                end else begin
                    model_mem[int'(a)] = d;
                    if (((who == 0) ? m0_err : m1_err) !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL rand_write_err m%0d: err=1 want 0", who);
                    end
                end
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            req_t[who] = 1'b0;
        end
    endtask

    task automatic test_random();
        int base0;
        int base1;
        apply_reset();
        slv_mem.delete();
        model_mem.delete();
        both_done  = 1'b0;
        err_seen   = 1'b0;
        rand_delay = 1'b1;
        noise_en   = 1'b1;
        base0 = done_cnt[0];
        base1 = done_cnt[1];
        fork
            drive(0, 20);
            drive(1, 20);
        join
        noise_en   = 1'b0;
        rand_delay = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (done_cnt[0] - base0 != 20 || done_cnt[1] - base1 != 20) begin
            tests_failed++;
            $display("FAIL rand_counts: m0=%0d m1=%0d want 20 20", done_cnt[0] - base0, done_cnt[1] - base1);
        end
        tests_run++;
        if (both_done !== 1'b0 || err_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_flags: both_done=%b err_seen=%b want 0 0", both_done, err_seen);
        end
    endtask

    initial begin
        rst   = 1'b0;
        req_t = 2'b00;
        wr_t  = 2'b00;
        test_reset();
        test_read_basic();
        test_write_delay();
        test_round_robin();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
